alu_control_multicycle: RTL and testbench

- Parametrised successor ALU control unit for the MIPS core.
- Decodes alu_op_i/alu_function_i into an ALU operation code for single-cycle instructions: R-type, I-type, loads/stores and branches.
- Also sequences multi-cycle MULT/MULTU/DIV/DIVU through an iterative HI/LO datapath, stalling the pipeline until the result is written.
- Sits between the main control unit and the ALU / mult-div unit.

---
 rtl/alu_control_multicycle_if.sv | 32 +++
 rtl/alu_control_multicycle.sv | 137 +++++++++++++
 tb/tb_alu_control_multicycle.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_control_multicycle_if.sv
// Decode-stage to ALU-control bundle: op class/funct in, ALU code and
// mult/div sequencing controls out.
interface alu_control_multicycle_if #(
    parameter int CTRL_WIDTH = 4,
    parameter int MD_CYCLES  = 32
);
    localparam int CNT_W = ($clog2(MD_CYCLES) < 1) ? 1 : $clog2(MD_CYCLES);

    logic [2:0]            alu_op_i;
    logic [5:0]            alu_function_i;
    logic                  valid_i;
    logic [CTRL_WIDTH-1:0] alu_operation_o;
    logic                  stall_o;
    logic                  md_start_o;
    logic [1:0]            md_op_o;
    logic                  md_step_o;
    logic [CNT_W-1:0]      md_count_o;
    logic                  hilo_we_o;
    logic                  md_done_o;

    modport master (
        output alu_op_i, alu_function_i, valid_i,
        input  alu_operation_o, stall_o, md_start_o, md_op_o,
        input  md_step_o, md_count_o, hilo_we_o, md_done_o
    );

    modport slave (
        input  alu_op_i, alu_function_i, valid_i,
        output alu_operation_o, stall_o, md_start_o, md_op_o,
        output md_step_o, md_count_o, hilo_we_o, md_done_o
    );
endinterface

// File: rtl/alu_control_multicycle.sv
// ALU control unit: combinational op decode plus an IDLE/RUN/DONE sequencer
// that stalls the pipeline while the iterative mult/div datapath runs.
module alu_control_multicycle #(
    parameter int CTRL_WIDTH = 4,
    parameter int MD_CYCLES  = 32,
    parameter int MD_ENABLE  = 1
) (
    input logic                      clk,
    input logic                      reset,
    alu_control_multicycle_if.slave  bus
);
    localparam int CNT_W = ($clog2(MD_CYCLES) < 1) ? 1 : $clog2(MD_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [1:0]       md_op_r;
    logic             md_req_s;
    logic [3:0]       op_code_s;

    // With mult/div disabled the MULT/DIV funct codes fall through to the default code.
    function automatic logic [3:0] decode_op(input logic [2:0] op, input logic [5:0] fn);
        logic [3:0] code;
        case (op)
            3'b111: begin
                case (fn)
                    6'b100000, 6'b100001: code = 4'b0011;
                    6'b100010:            code = 4'b0100;
                    6'b100100:            code = 4'b0000;
                    6'b100101:            code = 4'b0001;
                    6'b100111:            code = 4'b0101;
                    6'b101010:            code = 4'b0110;
                    6'b000000:            code = 4'b0010;
                    6'b000010:            code = 4'b0111;
                    6'b010000:            code = 4'b1010;
                    6'b010010:            code = 4'b1011;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011:
                        code = (MD_ENABLE != 0) ? 4'b1100 : 4'b1001;
                    default:              code = 4'b1001;
                endcase
            end
            3'b000, 3'b100: code = 4'b0011;
            3'b001:         code = 4'b0001;
            3'b010:         code = 4'b0000;
            3'b011:         code = 4'b1000;
            3'b101:         code = 4'b0110;
            3'b110:         code = 4'b0100;
            default:        code = 4'b1001;
        endcase
        return code;
    endfunction

    // Operation decode and mult/div request detection.
    always_comb begin
        op_code_s = decode_op(bus.alu_op_i, bus.alu_function_i);
        md_req_s  = bus.valid_i && (MD_ENABLE != 0) && (bus.alu_op_i == 3'b111)
                    && (bus.alu_function_i[5:2] == 4'b0110);
    end

    assign bus.alu_operation_o = CTRL_WIDTH'(op_code_s);
    assign bus.md_count_o      = count_r;

    // Sequencer state, iteration counter and captured mult/div opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= '0;
            md_op_r <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (md_req_s) begin
                        state_r <= ST_RUN;
                        count_r <= '0;
                        md_op_r <= bus.alu_function_i[1:0];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (count_r == LAST_COUNT) begin
                        state_r <= ST_DONE;
                        count_r <= '0;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    count_r <= '0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= '0;
                end
            endcase
        end
    end

    // Sequencing outputs; start and stall must rise in the detection cycle itself.
    always_comb begin
        bus.stall_o    = 1'b0;
        bus.md_start_o = 1'b0;
        bus.md_step_o  = 1'b0;
        bus.hilo_we_o  = 1'b0;
        bus.md_done_o  = 1'b0;
        bus.md_op_o    = md_op_r;
        case (state_r)
            ST_IDLE: begin
                if (md_req_s) begin
                    bus.stall_o    = 1'b1;
                    bus.md_start_o = 1'b1;
                    bus.md_op_o    = bus.alu_function_i[1:0];
                end else begin
                    bus.stall_o    = 1'b0;
                end
            end
            ST_RUN: begin
                bus.stall_o   = 1'b1;
                bus.md_step_o = 1'b1;
            end
            ST_DONE: begin
                bus.hilo_we_o = 1'b1;
                bus.md_done_o = 1'b1;
            end
            default: begin
                bus.stall_o = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_alu_control_multicycle.sv
// Scoreboard bench: stimulus pushes per-cycle expectations, negedge monitors
// pop and compare for the 32-cycle build and two 4-cycle builds.
module tb_alu_control_multicycle;
    typedef struct packed {
        logic [3:0] op;
        logic       stall;
        logic       start;
        logic       step;
        logic [4:0] cnt;
        logic       we;
        logic       done;
        logic [1:0] mdop;
    } rec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    rec_t  qa[$], qb[$], qc[$];
    string na[$], nb[$], nc[$];

    alu_control_multicycle_if #(.CTRL_WIDTH(4), .MD_CYCLES(32)) if_a ();
    alu_control_multicycle_if #(.CTRL_WIDTH(4), .MD_CYCLES(4))  if_b ();
    alu_control_multicycle_if #(.CTRL_WIDTH(4), .MD_CYCLES(4))  if_c ();

    alu_control_multicycle #(.CTRL_WIDTH(4), .MD_CYCLES(32), .MD_ENABLE(1))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    alu_control_multicycle #(.CTRL_WIDTH(4), .MD_CYCLES(4), .MD_ENABLE(0))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    alu_control_multicycle #(.CTRL_WIDTH(4), .MD_CYCLES(4), .MD_ENABLE(1))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));

    always #5 clk = ~clk;

    // {op, funct, expected code}; every entry applied with valid_i = 1.
    localparam int NVEC = 21;
    localparam logic [12:0] VEC [0:NVEC-1] = '{
        {3'b111, 6'b100000, 4'b0011}, {3'b111, 6'b100001, 4'b0011},
        {3'b111, 6'b100010, 4'b0100}, {3'b111, 6'b100100, 4'b0000},
        {3'b111, 6'b100101, 4'b0001}, {3'b111, 6'b100111, 4'b0101},
        {3'b111, 6'b101010, 4'b0110}, {3'b111, 6'b000000, 4'b0010},
        {3'b111, 6'b000010, 4'b0111}, {3'b111, 6'b010000, 4'b1010},
        {3'b111, 6'b010010, 4'b1011}, {3'b111, 6'b111111, 4'b1001},
        {3'b111, 6'b011100, 4'b1001}, {3'b000, 6'b101010, 4'b0011},
        {3'b100, 6'b000000, 4'b0011}, {3'b001, 6'b000000, 4'b0001},
        {3'b010, 6'b111111, 4'b0000}, {3'b011, 6'b011000, 4'b1000},
        {3'b101, 6'b000000, 4'b0110}, {3'b110, 6'b000000, 4'b0100},
        {3'b011, 6'b100010, 4'b1000}
    };

    function automatic rec_t mk(input logic [3:0] op, input logic stall, input logic start,
                                input logic step, input int cnt, input logic we,
                                input logic done, input logic [1:0] mdop);
        rec_t r;
        r.op = op; r.stall = stall; r.start = start; r.step = step;
        r.cnt = 5'(cnt); r.we = we; r.done = done; r.mdop = mdop;
        return r;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("op=%b stall=%b start=%b step=%b cnt=%0d we=%b done=%b mdop=%b",
                         r.op, r.stall, r.start, r.step, r.cnt, r.we, r.done, r.mdop);
    endfunction

    task automatic check(input string nm, input rec_t e, input rec_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t actual {%s} required {%s}", nm, $time, fmt(a), fmt(e));
        end
    endtask

    // Monitor: one expectation per DUT per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (qa.size() > 0)
            check(na.pop_front(), qa.pop_front(),
                  mk(if_a.alu_operation_o, if_a.stall_o, if_a.md_start_o, if_a.md_step_o,
                     int'(if_a.md_count_o), if_a.hilo_we_o, if_a.md_done_o, if_a.md_op_o));
        if (qb.size() > 0)
            check(nb.pop_front(), qb.pop_front(),
                  mk(if_b.alu_operation_o, if_b.stall_o, if_b.md_start_o, if_b.md_step_o,
                     int'(if_b.md_count_o), if_b.hilo_we_o, if_b.md_done_o, if_b.md_op_o));
        if (qc.size() > 0)
            check(nc.pop_front(), qc.pop_front(),
                  mk(if_c.alu_operation_o, if_c.stall_o, if_c.md_start_o, if_c.md_step_o,
                     int'(if_c.md_count_o), if_c.hilo_we_o, if_c.md_done_o, if_c.md_op_o));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [2:0] op, input logic [5:0] fn, input logic v);
        if_a.alu_op_i = op; if_a.alu_function_i = fn; if_a.valid_i = v;
    endtask

    task automatic set_bc(input logic [2:0] op, input logic [5:0] fn, input logic v);
        if_b.alu_op_i = op; if_b.alu_function_i = fn; if_b.valid_i = v;
        if_c.alu_op_i = op; if_c.alu_function_i = fn; if_c.valid_i = v;
    endtask

    task automatic push_a(input rec_t r, input string nm);
        qa.push_back(r); na.push_back(nm);
    endtask

    // Full 32-cycle operation; inputs switch to op1/fn1 from run index sw onwards.
    task automatic md_run(input logic [5:0] fn0, input logic [2:0] op1, input logic [5:0] fn1,
                          input logic [3:0] code1, input int sw, input string nm);
        logic [3:0] c;
        tick(); set_a(3'b111, fn0, 1'b1);
        push_a(mk(4'b1100, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, fn0[1:0]), {nm, "_start"});
        c = 4'b1100;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (k < sw) begin
                set_a(3'b111, fn0, 1'b1); c = 4'b1100;
            end else begin
                set_a(op1, fn1, 1'b1); c = code1;
            end
            push_a(mk(c, 1'b1, 1'b0, 1'b1, k, 1'b0, 1'b0, fn0[1:0]), {nm, "_run"});
        end
        tick();
        push_a(mk(c, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, fn0[1:0]), {nm, "_done"});
        tick(); set_a(3'b000, 6'b000000, 1'b0);
        push_a(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, fn0[1:0]), {nm, "_idle"});
    endtask

    // 4-cycle builds: enabled one sequences, disabled one decodes as default.
    task automatic small_md(input logic [5:0] fn, input string nm);
        tick(); set_bc(3'b111, fn, 1'b1);
        qb.push_back(mk(4'b1001, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00)); nb.push_back({nm, "_off"});
        qc.push_back(mk(4'b1100, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, fn[1:0])); nc.push_back({nm, "_start"});
        for (int k = 0; k < 4; k++) begin
            tick(); set_bc(3'b000, 6'b000000, 1'b0);
            qb.push_back(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00)); nb.push_back({nm, "_off_idle"});
            qc.push_back(mk(4'b0011, 1'b1, 1'b0, 1'b1, k, 1'b0, 1'b0, fn[1:0])); nc.push_back({nm, "_run"});
        end
        tick();
        qb.push_back(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00)); nb.push_back({nm, "_off_idle"});
        qc.push_back(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, fn[1:0])); nc.push_back({nm, "_done"});
        tick();
        qc.push_back(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, fn[1:0])); nc.push_back({nm, "_idle"});
    endtask

    initial begin
        logic [12:0] v;
        set_a(3'b000, 6'b000000, 1'b0);
        set_bc(3'b000, 6'b000000, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_a(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00), "reset_a");
        qb.push_back(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00)); nb.push_back("reset_b");
        qc.push_back(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00)); nc.push_back("reset_c");
        tick(); reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            v = VEC[i];
            tick(); set_a(v[12:10], v[9:4], 1'b1);
            push_a(mk(v[3:0], 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00), $sformatf("decode_%0d", i));
        end
        tick(); set_a(3'b111, 6'b011011, 1'b0);
        push_a(mk(4'b1100, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00), "divu_not_valid");

        md_run(6'b011001, 3'b111, 6'b011001, 4'b1100, 99, "multu");
        md_run(6'b011010, 3'b111, 6'b011000, 4'b1100, 10, "div_chg");
        md_run(6'b011011, 3'b111, 6'b100010, 4'b0100, 16, "divu_sub");

        // Abort a MULTU at count 5; the reset cycle itself is not checked.
        tick(); set_a(3'b111, 6'b011001, 1'b1);
        push_a(mk(4'b1100, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'b01), "abort_start");
        for (int k = 0; k < 5; k++) begin
            tick(); set_a(3'b000, 6'b000000, 1'b0);
            push_a(mk(4'b0011, 1'b1, 1'b0, 1'b1, k, 1'b0, 1'b0, 2'b01), "abort_run");
        end
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        push_a(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00), "abort_idle");
        for (int k = 0; k < 40; k++) begin
            tick();
            push_a(mk(4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'b00), "abort_no_we");
        end

        small_md(6'b011000, "small_mult");
        small_md(6'b011010, "small_div");

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
